// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB master and completer.
//   - APB_ADDR_W / APB_DATA_W : bus widths (8-bit address, 8-bit data)
//   - apb_state_e             : bus-phase state encoding (SETUP is used by the
//                               master; the completer folds it into IDLE)
//   - addr_err()              : out-of-range address decode helper
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // True when the address falls outside a register file of num_regs entries.
    function automatic logic addr_err(input logic [APB_ADDR_W-1:0] addr,
                                      input int unsigned num_regs);
        return 32'(addr) >= num_regs;
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: NUM_REGS x 8-bit register storage.
//   clk, preset : clock and synchronous active-high reset (all entries <= RESET_VAL)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [APB_DATA_W-1:0] RESET_VAL = 8'h00,
    localparam int                   IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // For non power-of-two sizes an out-of-range index can reach here; the
    // caller masks that case with its latched error flag.
    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer backed by a small 8-bit register file.
//   clk, preset          : clock, synchronous active-high reset
//   psel, penable        : APB select / access strobe from the master
//   pwrite, paddress     : direction and address (latched in the SETUP cycle)
//   pwdata               : write data (used in the completing ACCESS cycle)
//   pready               : transfer completes this cycle (combinational)
//   prdata, pslverr      : read data / error response, valid with pready
//   reg_wr_pulse         : one-cycle pulse following each committed write
//
// Handshake: a transfer is a SETUP cycle (psel=1, penable=0) followed by one
// or more ACCESS cycles (psel=1, penable=1); it completes in the first ACCESS
// cycle where pready=1, which is ACCESS cycle WAIT_STATES+1. Dropping psel in
// ACCESS aborts; dropping penable with psel held restarts as a new SETUP.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 1,
    parameter logic [APB_DATA_W-1:0] RESET_VAL   = 8'h00
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddress,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic                  pready,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pslverr,
    output logic                  reg_wr_pulse
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e            state_q;
    logic [3:0]            wcnt_q;
    logic [IDX_W-1:0]      addr_q;
    logic                  write_q;
    logic                  err_q;
    logic                  commit;
    logic [APB_DATA_W-1:0] rf_rdata;

    // Only the index bits are kept: anything above them is out of range and
    // already captured in err_q.
    always_ff @(posedge clk) begin
        if (preset) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            reg_wr_pulse <= 1'b0;
        end else begin
            reg_wr_pulse <= commit;
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        wcnt_q  <= 4'(WAIT_STATES);
                        addr_q  <= paddress[IDX_W-1:0];
                        write_q <= pwrite;
                        err_q   <= addr_err(paddress, NUM_REGS);
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (!penable) begin
                        // Master restarted: treat as a fresh SETUP.
                        wcnt_q  <= 4'(WAIT_STATES);
                        addr_q  <= paddress[IDX_W-1:0];
                        write_q <= pwrite;
                        err_q   <= addr_err(paddress, NUM_REGS);
                    end else if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        pready  = (state_q == ACCESS) && psel && penable && (wcnt_q == '0);
        commit  = pready && write_q && !err_q;
        pslverr = pready && err_q;
        prdata  = (pready && !write_q && !err_q) ? rf_rdata : '0;
    end

    apb_regfile #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk   (clk),
        .preset(preset),
        .we    (commit),
        .waddr (addr_q),
        .wdata (pwdata),
        .raddr (addr_q),
        .rdata (rf_rdata)
    );

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB completer for the 8-bit APB bus driven by the team's APB master.
- Decodes setup/access phases and inserts a fixed number of wait states.
- Backs the bus with a small 8-bit register file.
- Flags out-of-range addresses with pslverr. Sits at the far end of the master's psel/penable/pwrite/paddress/pwdata bus.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; valid addresses are 0..NUM_REGS-1 (NUM_REGS must be 1..256).
- WAIT_STATES, 1, ACCESS cycles with pready=0 before completion (0..15).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  bus clock; all state changes on rising edge.
- preset  input  1  reset; synchronous, active-high.
- psel  input  1  slave select from master.
- penable  input  1  access-phase strobe from master.
- pwrite  input  1  1=write, 0=read; sampled with psel.
- paddress  input  8  register address.
- pwdata  input  8  write data.
- pready  output  1  transfer completes in this cycle.
- prdata  output  8  read data; valid only when pready=1 and pwrite=0.
- pslverr  output  1  error response; valid only when pready=1.
- reg_wr_pulse  output  1  one-cycle pulse after each committed register write.

Behaviour:
- Reset:
  - Sampled on the rising edge of clk while preset=1.
  - Reset values: state=IDLE, wait counter=0, all registers=RESET_VAL, reg_wr_pulse=0. The combinational outputs pready, prdata and pslverr evaluate to 0 in IDLE.
  - Reset mid-transfer aborts the transfer with no write.
- States: IDLE, ACCESS (2-bit encoding, shared package).
- IDLE:
  - pready=0, pslverr=0, prdata=0.
  - psel=1 and penable=0 is the SETUP cycle. At the edge: state<=ACCESS, wcnt<=WAIT_STATES.
  - Latch addr_q=paddress, write_q=pwrite and err_q=(paddress>=NUM_REGS) at the same edge.
  - psel=1 and penable=1 without a preceding SETUP is ignored; stay in IDLE.
- ACCESS:
  - pready = psel & penable & (wcnt==0), combinational.
  - When wcnt!=0 and psel=1: wcnt decrements each edge.
  - At the edge where pready=1:
    - If write_q=1 and err_q=0: reg[addr_q] <= pwdata, and reg_wr_pulse=1 for the following cycle.
    - state<=IDLE.
  - psel=0 in ACCESS (master abort): state<=IDLE, no write, no pready.
  - penable=0 with psel=1 in ACCESS: treated as a new SETUP. Reload wcnt, relatch address/direction, and drop the old transfer.
- Read data: prdata = (pready & ~write_q & ~err_q) ? reg[addr_q] : 0.
- Error:
  - pslverr = pready & err_q.
  - An error write leaves all registers unchanged; an error read returns 0.
- Latency:
  - With WAIT_STATES=0: one SETUP cycle plus one ACCESS cycle (pready high on the first ACCESS cycle).
  - In general, pready is first high on ACCESS cycle WAIT_STATES+1.
- Back-to-back: the cycle after completion may be the next SETUP. IDLE accepts it immediately, so there are no dead cycles beyond the protocol minimum.
- Read-after-write: a read of the address written by the immediately preceding transfer returns the new value.
- reg_wr_pulse is never asserted for reads, errored writes or aborted transfers.

Decomposition:
- Shared package apb_pkg:
  - state typedef/encoding: IDLE=2'b00, ACCESS=2'b10; 2'b01 is reserved for SETUP and kept consistent with the master.
  - APB_ADDR_W=8, APB_DATA_W=8.
- One natural sub-module, apb_regfile: NUM_REGS x 8 storage with synchronous write port (we, waddr, wdata), combinational read port and synchronous reset to RESET_VAL.
- The FSM, wait counter and error decode stay in apb_slave_regs.

Test Plan:
- Write then read, WAIT_STATES=1:
  - SETUP write addr 8'h03, data 8'hA5 -> pready=1 on ACCESS cycle 2, pslverr=0, reg_wr_pulse=1 the next cycle.
  - Then read addr 8'h03 -> prdata=8'hA5 with pready=1.
- Out of range, NUM_REGS=16:
  - Write addr 8'h20, data 8'h55 -> pready=1, pslverr=1, no reg_wr_pulse.
  - Subsequent reads of 8'h00..8'h0F return RESET_VAL (8'h00).
  - Read of 8'h20 -> pslverr=1, prdata=0.
- Back-to-back, WAIT_STATES=0:
  - Four consecutive writes to 8'h00..8'h03 (data 8'h11, 8'h22, 8'h33, 8'h44), each exactly 2 cycles with no idle gap -> pready high every second cycle.
  - Readback returns 11/22/33/44.
- Abort: write 8'h05, data 8'hFF, with psel dropped on ACCESS cycle 1 (WAIT_STATES=2) -> no pready, reg[5] stays 8'h00, state back to IDLE.
- Reset mid-operation:
  - Write 8'h07, data 8'h3C, completed.
  - Start a write to 8'h07 with data 8'hC3; assert preset=1 during ACCESS -> pready/pslverr/prdata=0 the next cycle.
  - A later read of 8'h07 returns 8'h00.
- Protocol violation: psel=1 and penable=1 asserted from IDLE with no SETUP -> pready stays 0 and no write, until a proper SETUP is presented.
